// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the FIFO-draining UART transmitter
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int FRAME_CNT_W    = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter flagging the last cycle of each bit period
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_l,
   input  logic restart,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Count 0..CLKS_PER_BIT-1 continuously while a frame is on the line; held at 0 otherwise
   always_ff @(posedge clk) begin
      if (!rst_l || restart) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Held-off while restarting so a stale count can never end a bit early
   assign bit_end = (cnt == LAST) && !restart;

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the FIFO read side and serialises them as UART frames
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic                   enable,
   input  logic                   fifo_empty,
   input  logic [7:0]             fifo_read_data,
   output logic                   fifo_read_en,
   output logic                   tx,
   output logic                   busy,
   output logic                   tx_done,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   tx_state_e                 state;
   tx_state_e                 state_nx;
   logic [UART_DATA_BITS-1:0] shift;
   logic                      parity;
   logic [2:0]                bit_cnt;
   logic                      bit_end;
   logic                      restart;
   logic                      last_data;
   logic                      last_stop;

   // The bit timer only runs once the byte is in hand, so START always gets a full period
   assign restart   = (state == ST_IDLE) || (state == ST_REQ) || (state == ST_WAIT);
   assign last_data = (bit_cnt == LAST_DATA);
   assign last_stop = (bit_cnt == LAST_STOP);

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst_l   (rst_l),
      .restart (restart),
      .bit_end (bit_end)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode; every output is decoded from the state register so none can glitch on inputs
   always_comb begin
      state_nx     = state;
      tx           = 1'b1;
      fifo_read_en = 1'b0;
      busy         = 1'b1;
      tx_done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (enable && !fifo_empty) begin
               state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            fifo_read_en = 1'b1;
            state_nx     = ST_WAIT;
         end
         ST_WAIT: begin
            state_nx = ST_START;
         end
         ST_START: begin
            tx = 1'b0;
            if (bit_end) begin
               state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            tx = shift[0];
            if (bit_end && last_data) begin
               state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            tx = parity;
            if (bit_end) begin
               state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end && last_stop) begin
               tx_done  = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Byte capture, LSB-first shifting, bit/stop counting and the completed-frame counter
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         shift       <= '0;
         parity      <= 1'b0;
         bit_cnt     <= '0;
         frame_count <= '0;
      end else begin
         if (state == ST_WAIT) begin
            shift   <= fifo_read_data;
            parity  <= (^fifo_read_data) ^ (PARITY_ODD != 0);
            bit_cnt <= '0;
         end else if (bit_end) begin
            if (state == ST_DATA) begin
               shift   <= shift >> 1;
               bit_cnt <= last_data ? 3'd0 : bit_cnt + 3'd1;
            end else if (state == ST_STOP) begin
               bit_cnt <= last_stop ? 3'd0 : bit_cnt + 3'd1;
            end
         end
         if (tx_done) begin
            frame_count <= frame_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - bench for fifo_uart_tx across three frame formats
module tb_fifo_uart_tx;

   localparam int CPB = 4;
   localparam int ND  = 3;
   localparam int P_EN   [ND] = '{0, 1, 1};
   localparam int P_ODD  [ND] = '{0, 0, 1};
   localparam int N_STOP [ND] = '{1, 1, 2};

   logic          clk = 1'b0;
   logic          rst_l;
   logic          enable;
   logic [ND-1:0] fifo_empty;
   logic [ND-1:0] fifo_read_en;
   logic [ND-1:0] tx;
   logic [ND-1:0] busy;
   logic [ND-1:0] tx_done;
   logic [7:0]    fifo_read_data [ND];
   logic [15:0]   frame_count    [ND];

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst_l(rst_l), .enable(enable), .fifo_empty(fifo_empty[0]),
      .fifo_read_data(fifo_read_data[0]), .fifo_read_en(fifo_read_en[0]), .tx(tx[0]),
      .busy(busy[0]), .tx_done(tx_done[0]), .frame_count(frame_count[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst_l(rst_l), .enable(enable), .fifo_empty(fifo_empty[1]),
      .fifo_read_data(fifo_read_data[1]), .fifo_read_en(fifo_read_en[1]), .tx(tx[1]),
      .busy(busy[1]), .tx_done(tx_done[1]), .frame_count(frame_count[1]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst_l(rst_l), .enable(enable), .fifo_empty(fifo_empty[2]),
      .fifo_read_data(fifo_read_data[2]), .fifo_read_en(fifo_read_en[2]), .tx(tx[2]),
      .busy(busy[2]), .tx_done(tx_done[2]), .frame_count(frame_count[2]));

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   byte unsigned fq [ND][$];
   logic [1:0]   eq [ND][$];
   bit           pend     [ND];
   int           pop_seen [ND];
   int           pop_done [ND];
   int           m_fcnt   [ND];
   int           act_pops [ND];
   int           pop_cyc  [ND];
   int           done_cyc [ND];
   int           gap      [ND];
   logic [11:0]  rec      [ND];

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
      end
   endtask

   task automatic build_frame(input int d, input logic [7:0] b);
      logic par;
      par = (^b) ^ (P_ODD[d] != 0);
      eq[d].push_back(2'b01);
      for (int k = 0; k < CPB; k++) eq[d].push_back(2'b00);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < CPB; k++) eq[d].push_back({1'b0, b[i]});
      if (P_EN[d] != 0)
         for (int k = 0; k < CPB; k++) eq[d].push_back({1'b0, par});
      for (int k = 0; k < N_STOP[d] * CPB; k++)
         eq[d].push_back({k == N_STOP[d] * CPB - 1, 1'b1});
   endtask

   function automatic bit model_idle();
      for (int d = 0; d < ND; d++)
         if (eq[d].size() != 0 || pend[d] || fq[d].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < ND; d++) begin
            logic [1:0] e;
            logic       x_re;
            logic       x_busy;
            if (fifo_read_en[d] === 1'b1) pop_seen[d]++;
            if (!rst_l) begin
               eq[d].delete();
               pend[d]   = 1'b0;
               m_fcnt[d] = 0;
            end else begin
               if (fifo_read_en[d] === 1'b1) begin
                  gap[d]     = cyc - done_cyc[d] + 1;
                  act_pops[d]++;
                  pop_cyc[d] = cyc;
               end
               if (tx_done[d] === 1'b1) done_cyc[d] = cyc;
               for (int i = 0; i < 12; i++)
                  if (cyc - pop_cyc[d] == 4 + 4 * i) rec[d][i] = tx[d];
               if (eq[d].size() > 0) begin
                  e      = eq[d].pop_front();
                  x_re   = 1'b0;
                  x_busy = 1'b1;
               end else if (pend[d]) begin
                  e       = 2'b01;
                  x_re    = 1'b1;
                  x_busy  = 1'b1;
                  pend[d] = 1'b0;
                  if (fq[d].size() > 0) build_frame(d, fq[d][0]);
               end else begin
                  e      = 2'b01;
                  x_re   = 1'b0;
                  x_busy = 1'b0;
                  if (enable && fq[d].size() > 0) pend[d] = 1'b1;
               end
               chk("tx", d, 32'(tx[d]), 32'(e[0]));
               chk("busy", d, 32'(busy[d]), 32'(x_busy));
               chk("fifo_read_en", d, 32'(fifo_read_en[d]), 32'(x_re));
               chk("tx_done", d, 32'(tx_done[d]), 32'(e[1]));
               chk("frame_count", d, 32'(frame_count[d]), 32'(m_fcnt[d] % 65536));
               if (e[1]) m_fcnt[d]++;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         while (pop_done[d] < pop_seen[d]) begin
            if (fq[d].size() > 0) fifo_read_data[d] = fq[d].pop_front();
            pop_done[d]++;
         end
         fifo_empty[d] = (fq[d].size() == 0);
      end
   endtask

   task automatic push_all(input logic [7:0] b);
      for (int d = 0; d < ND; d++) begin
         fq[d].push_back(b);
         fifo_empty[d] = 1'b0;
      end
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (!model_idle() && n < limit) begin
         step();
         n++;
      end
      n_checks++;
      if (!model_idle()) begin
         n_fail++;
         $display("FAIL wait_idle: traffic still pending after %0d cycles", limit);
      end
      repeat (3) step();
   endtask

   task automatic wait_pop(input int limit);
      int n     = 0;
      int start = act_pops[0];
      while (act_pops[0] == start && n < limit) begin
         step();
         n++;
      end
      chk("wait_pop_seen", 0, 32'(act_pops[0] != start), 32'd1);
   endtask

   task automatic run_test();
      int p0;
      int bad_tx;
      int bad_busy;
      for (int d = 0; d < ND; d++) begin
         pend[d] = 1'b0; pop_seen[d] = 0; pop_done[d] = 0; m_fcnt[d] = 0;
         act_pops[d] = 0; pop_cyc[d] = -1000; done_cyc[d] = -1000; gap[d] = 0; rec[d] = '0;
         fifo_read_data[d] = 8'h00;
      end
      rst_l      = 1'b0;
      enable     = 1'b0;
      fifo_empty = '1;
      repeat (3) step();
      rst_l = 1'b1;
      step();
      for (int d = 0; d < ND; d++) begin
         chk("reset_tx", d, 32'(tx[d]), 32'd1);
         chk("reset_busy", d, 32'(busy[d]), 32'd0);
         chk("reset_read_en", d, 32'(fifo_read_en[d]), 32'd0);
         chk("reset_frame_count", d, 32'(frame_count[d]), 32'd0);
      end

      // 0xA5: start, 1,0,1,0,0,1,0,1, stop
      enable = 1'b1;
      push_all(8'hA5);
      wait_idle(300);
      chk("a5_bits", 0, 32'(rec[0][9:0]), 32'h34A);
      chk("a5_pops", 0, 32'(act_pops[0]), 32'd1);
      chk("a5_frame_count", 0, 32'(frame_count[0]), 32'd1);
      chk("a5_len", 0, 32'(done_cyc[0] - pop_cyc[0]), 32'd41);

      // 0x07: three ones, so even parity 1 and odd parity 0
      push_all(8'h07);
      wait_idle(300);
      chk("p07_even_parity", 1, 32'(rec[1][9]), 32'd1);
      chk("p07_odd_parity", 2, 32'(rec[2][9]), 32'd0);
      chk("p07_len_1stop", 1, 32'(done_cyc[1] - pop_cyc[1]), 32'd45);
      chk("p07_len_2stop", 2, 32'(done_cyc[2] - pop_cyc[2]), 32'd49);

      // Three queued bytes go out back to back after a fresh reset
      rst_l = 1'b0;
      step();
      rst_l = 1'b1;
      step();
      push_all(8'h11);
      push_all(8'h22);
      push_all(8'h33);
      wait_idle(600);
      chk("b2b_frame_count", 2, 32'(frame_count[2]), 32'd3);
      chk("b2b_frame_count", 0, 32'(frame_count[0]), 32'd3);
      chk("b2b_idle_gap", 2, 32'(gap[2]), 32'd3);
      chk("b2b_idle_gap", 0, 32'(gap[0]), 32'd3);
      chk("b2b_last_bits", 0, 32'(rec[0][9:0]), 32'h266);

      // Empty FIFO with enable high: nothing may move
      p0       = act_pops[0] + act_pops[1] + act_pops[2];
      bad_tx   = 0;
      bad_busy = 0;
      repeat (100) begin
         step();
         if (tx !== 3'b111) bad_tx++;
         if (busy !== 3'b000) bad_busy++;
      end
      chk("empty_pops", 0, 32'(act_pops[0] + act_pops[1] + act_pops[2] - p0), 32'd0);
      chk("empty_tx_low", 0, 32'(bad_tx), 32'd0);
      chk("empty_busy", 0, 32'(bad_busy), 32'd0);

      // Drop enable during data bit 3 of 0x3C while 0x55 waits behind it
      push_all(8'h3C);
      push_all(8'h55);
      wait_pop(50);
      repeat (18) step();
      enable = 1'b0;
      p0     = act_pops[0] + act_pops[1] + act_pops[2];
      repeat (80) step();
      chk("disable_pops", 0, 32'(act_pops[0] + act_pops[1] + act_pops[2] - p0), 32'd0);
      chk("disable_left", 0, 32'(fq[0].size()), 32'd1);
      chk("disable_bits", 0, 32'(rec[0][9:0]), 32'h278);
      chk("disable_frame_count", 0, 32'(frame_count[0]), 32'd4);
      enable = 1'b1;
      wait_idle(300);
      chk("reenable_frame_count", 0, 32'(frame_count[0]), 32'd5);

      // One-cycle reset during START of 0x81; 0x42 must follow normally
      push_all(8'h81);
      push_all(8'h42);
      wait_pop(50);
      repeat (2) step();
      rst_l = 1'b0;
      step();
      rst_l = 1'b1;
      for (int d = 0; d < ND; d++) begin
         chk("midreset_tx", d, 32'(tx[d]), 32'd1);
         chk("midreset_busy", d, 32'(busy[d]), 32'd0);
         chk("midreset_frame_count", d, 32'(frame_count[d]), 32'd0);
      end
      wait_idle(300);
      chk("after_reset_bits", 0, 32'(rec[0][9:0]), 32'h284);
      chk("after_reset_frame_count", 0, 32'(frame_count[0]), 32'd1);
      chk("after_reset_frame_count", 2, 32'(frame_count[2]), 32'd1);
   endtask

   initial begin
      fork
         monitor();
         run_test();
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer stage for async_fifo. Sits in the FIFO read-clock domain.
- Pops bytes whenever the FIFO is non-empty and enabled, then serialises each byte as a UART frame on tx.
- Frame format: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Gives the async_fifo tests a real draining consumer.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  single clock (FIFO read clock).
- rst_l  input  1  synchronous reset, active-low.
- enable  input  1  permits starting new frames.
- fifo_empty  input  1  FIFO mem_empty.
- fifo_read_data  input  8  FIFO read_data; valid the cycle after fifo_read_en is high.
- fifo_read_en  output  1  FIFO pop strobe.
- tx  output  1  serial line, idle high.
- busy  output  1  high from REQ through the final stop bit.
- tx_done  output  1  one-cycle pulse at frame completion.
- frame_count  output  16  frames sent, wrapping.

Behaviour:
- Reset: all state is sampled on posedge clk when rst_l=0. Reset values:
  - tx=1, fifo_read_en=0, busy=0, tx_done=0, frame_count=0.
  - state=IDLE; bit and cycle counters=0; shift register=0.
- States: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0, go to REQ; otherwise stay in IDLE.
- REQ: fifo_read_en=1 for exactly this one cycle (decoded from the state register). Next state is WAIT.
- WAIT: fifo_read_data is valid. Capture it into the shift register and the parity accumulator. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit; 8 bits total.
- PARITY (only when PARITY_EN=1): tx = XOR of the data bits, XOR PARITY_ODD, for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final stop cycle: assert tx_done for 1 cycle, increment frame_count (mod 2^16), and go to IDLE.
- Bit timing: the cycle counter runs 0..CLKS_PER_BIT-1 with width $clog2(CLKS_PER_BIT). Every bit lasts exactly CLKS_PER_BIT cycles; no drift across the frame.
- Back-to-back frames: the minimum idle-high gap between the last stop cycle and the next start bit is 3 cycles (IDLE, REQ, WAIT).
- busy=1 in every state except IDLE.
- fifo_read_en is never asserted while fifo_empty=1 is sampled in IDLE, so there is no underflow pop. fifo_empty is ignored outside IDLE.
- enable deasserted mid-frame: the current frame completes unaltered; no further REQ.
- enable deasserted during REQ/WAIT: the popped byte is still transmitted. A popped byte is never dropped except by reset.
- Reset mid-frame: on the reset edge tx=1 and state=IDLE. The in-flight byte is discarded and frame_count=0.
- tx_done and the fifo_read_en pulse never overlap.

Decomposition:
- Package uart_pkg:
  - tx_state_e enum covering the 7 states.
  - UART_DATA_BITS=8.
  - FRAME_CNT_W=16.
- One sub-module, uart_bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst_l, restart.
  - Output: bit_end pulse on the last cycle of each bit period.
- The FSM, shift register and parity logic stay in fifo_uart_tx.

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5, enable=1:
  - Exactly one fifo_read_en pulse.
  - tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - tx_done pulses once; frame_count=1.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07:
  - Parity bit=1. Frame length (1+8+1+1)*CLKS_PER_BIT cycles.
  - Repeat with PARITY_ODD=1: parity bit=0.
- FIFO preloaded with 0x11, 0x22, 0x33, STOP_BITS=2:
  - Three frames in order.
  - Each stop period is 2*CLKS_PER_BIT cycles.
  - Idle gap between frames is exactly 3 cycles.
  - frame_count=3.
- fifo_empty=1 with enable=1 for 100 cycles:
  - fifo_read_en stays 0, tx stays 1, busy stays 0.
- Drop enable during DATA bit 3 of byte 0x3C while the FIFO still has data:
  - Frame finishes correctly.
  - No further fifo_read_en until enable returns to 1.
- Assert rst_l=0 for 1 cycle during START:
  - Next cycle: tx=1, busy=0, frame_count=0.
  - After release, the next FIFO byte transmits normally.
